// File: rtl/result_drain_packer.sv
// result_drain_packer: drains a programmed number of FP24 results from the
// result FIFO (1-cycle read latency) and packs them eight per 256-bit beat,
// one result per 32-bit lane, presented on a valid/ready stream.
module result_drain_packer #(
    parameter int LANES = 8,
    parameter int CNT_W = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [CNT_W-1:0]      i_drain_count,
    output logic                  o_result_fifo_ren,
    input  logic [23:0]           i_result_fifo_rdata,
    input  logic                  i_result_fifo_empty,
    output logic [LANES*32-1:0]   o_out_data,
    output logic [LANES-1:0]      o_out_lane_mask,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_out_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [11:0]           o_beats_sent,
    output logic [1:0]            o_state
);

    localparam int LW = $clog2(LANES + 1);
    localparam int LI = $clog2(LANES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W:0]    remaining_rd;
    logic [LW-1:0]     lane_rd;
    logic [LW-1:0]     lane_wr;
    logic [LI-1:0]     wr_lane;
    logic              rd_pending;
    logic              ren;
    logic              fill_done;

    // Read request and beat-complete conditions from registered state.
    always_comb begin
        ren       = (state == ST_FILL) && !i_result_fifo_empty &&
                    (remaining_rd != '0) && (lane_rd < LW'(LANES));
        // The read landing on this edge is counted as landed, so the beat
        // is presented the cycle right after the final write.
        fill_done = (state == ST_FILL) &&
                    ((lane_wr + LW'(rd_pending)) == lane_rd) &&
                    ((lane_rd == LW'(LANES)) || (remaining_rd == '0));
        wr_lane   = lane_wr[LI-1:0];
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = (i_drain_count == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_done) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_out_ready) begin
                    state_next = (remaining_rd != '0) ? ST_FILL : ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        o_result_fifo_ren = ren;
        o_out_valid       = (state == ST_SEND);
        o_busy            = (state == ST_FILL) || (state == ST_SEND);
        o_done            = (state == ST_DONE);
        o_state           = state;
    end

    // Counters, lane packing and beat bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            remaining_rd    <= '0;
            lane_rd         <= '0;
            lane_wr         <= '0;
            rd_pending      <= 1'b0;
            o_out_data      <= '0;
            o_out_lane_mask <= '0;
            o_out_last      <= 1'b0;
            o_beats_sent    <= '0;
        end else begin
            rd_pending <= ren;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        remaining_rd    <= {1'b0, i_drain_count};
                        lane_rd         <= '0;
                        lane_wr         <= '0;
                        o_out_data      <= '0;
                        o_out_lane_mask <= '0;
                        o_out_last      <= 1'b0;
                        o_beats_sent    <= '0;
                    end
                end
                ST_FILL: begin
                    if (ren) begin
                        remaining_rd <= remaining_rd - (CNT_W+1)'(1);
                        lane_rd      <= lane_rd + LW'(1);
                    end
                    if (rd_pending) begin
                        o_out_data[{wr_lane, 5'b0} +: 32] <= {8'h00, i_result_fifo_rdata};
                        o_out_lane_mask[wr_lane]          <= 1'b1;
                        lane_wr                           <= lane_wr + LW'(1);
                    end
                    if (fill_done) begin
                        o_out_last <= (remaining_rd == '0);
                    end
                end
                ST_SEND: begin
                    if (i_out_ready) begin
                        o_beats_sent    <= o_beats_sent + 12'd1;
                        o_out_data      <= '0;
                        o_out_lane_mask <= '0;
                        o_out_last      <= 1'b0;
                        lane_rd         <= '0;
                        lane_wr         <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_drain_packer.sv
// Bench for result_drain_packer: a queue-based result FIFO, a drain-level
// reference model (counts, beat contents in FIFO order) compared every
// cycle, directed scenarios with literal expectations, then random drains.
module tb_result_drain_packer;

    localparam int CNT_W = 15;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_start = 1'b0;
    logic [CNT_W-1:0]  i_drain_count = '0;
    logic              o_result_fifo_ren;
    logic [23:0]       i_result_fifo_rdata = '0;
    logic              i_result_fifo_empty = 1'b1;
    logic [255:0]      o_out_data;
    logic [7:0]        o_out_lane_mask;
    logic              o_out_valid;
    logic              i_out_ready = 1'b0;
    logic              o_out_last;
    logic              o_busy;
    logic              o_done;
    logic [11:0]       o_beats_sent;
    logic [1:0]        o_state;

    always #5 i_clk = ~i_clk;

    result_drain_packer #(.LANES(8), .CNT_W(CNT_W)) dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_start             (i_start),
        .i_drain_count       (i_drain_count),
        .o_result_fifo_ren   (o_result_fifo_ren),
        .i_result_fifo_rdata (i_result_fifo_rdata),
        .i_result_fifo_empty (i_result_fifo_empty),
        .o_out_data          (o_out_data),
        .o_out_lane_mask     (o_out_lane_mask),
        .o_out_valid         (o_out_valid),
        .i_out_ready         (i_out_ready),
        .o_out_last          (o_out_last),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_beats_sent        (o_beats_sent),
        .o_state             (o_state)
    );

    // Result FIFO model: one write port driven by the stimulus, 1-cycle read.
    logic [23:0] fifo_q[$];
    logic [23:0] ref_words[$];
    int          pops = 0;
    logic        push_valid = 1'b0;
    logic [23:0] push_data = '0;
    logic        flush = 1'b0;

    always @(posedge i_clk) begin
        logic [23:0] w;
        if (flush) fifo_q.delete();
        if (o_result_fifo_ren && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            i_result_fifo_rdata <= w;
            pops = pops + 1;
        end
        if (push_valid) begin
            fifo_q.push_back(push_data);
            ref_words.push_back(push_data);
        end
        i_result_fifo_empty <= (fifo_q.size() == 0);
    end

    // Scoreboard state (written only by the compare process).
    int          n_checks = 0;
    int          n_fail = 0;
    int          scen = 0;
    logic        timed_out = 1'b0;
    bit          to_rep = 0;
    bit          armed = 0;
    bit          rst_prev = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_left = 0;
    int          m_count = 0;
    int          m_beats = 0;
    int          ref_idx = 0;
    int          pops0 = 0;
    int          cyc = 0;
    int          start_scen = -1;
    bit          prev_stall = 0;
    logic [255:0] prev_data = '0;
    logic [7:0]  prev_mask = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare DUT outputs against the drain-level model every cycle.
    always @(negedge i_clk) begin
        logic [255:0] ed;
        logic [255:0] lit;
        logic [7:0]   em;
        logic [7:0]   mask_tbl [3];
        int           n;
        bit           nd;
        mask_tbl[0] = 8'hFF; mask_tbl[1] = 8'hFF; mask_tbl[2] = 8'h0F;
        cyc = cyc + 1;
        if (armed) begin
            if (timed_out && !to_rep) begin
                chk("drain_completes", 256'(timed_out), 256'(0));
                to_rep = 1;
            end
            if (rst_prev) begin
                chk("rst_valid", o_out_valid, 0);
                chk("rst_data", o_out_data, 0);
                chk("rst_mask", o_out_lane_mask, 0);
                chk("rst_last", o_out_last, 0);
                chk("rst_busy", o_busy, 0);
                chk("rst_done", o_done, 0);
                chk("rst_beats", o_beats_sent, 0);
                chk("rst_state", o_state, 0);
                chk("rst_ren", o_result_fifo_ren, 0);
            end
            chk("busy", o_busy, m_busy);
            chk("done", o_done, m_done);
            chk("beats_sent", o_beats_sent, m_beats);
            if (!m_busy) begin
                chk("ren_idle", o_result_fifo_ren, 0);
                chk("valid_idle", o_out_valid, 0);
                chk("state_idle_done", o_state, m_done ? 3 : 0);
            end
            if (o_result_fifo_ren) chk("ren_not_empty", i_result_fifo_empty, 0);
            if (prev_stall) begin
                chk("valid_held", o_out_valid, 1);
                chk("data_stable", o_out_data, prev_data);
                chk("mask_stable", o_out_lane_mask, prev_mask);
                chk("last_stable", o_out_last, prev_last);
            end
            if (o_out_valid && m_busy) begin
                n = (m_left < 8) ? m_left : 8;
                ed = '0;
                em = '0;
                for (int i = 0; i < n; i++) begin
                    ed[i*32 +: 32] = {8'h00, ref_words[ref_idx + i]};
                    em[i] = 1'b1;
                end
                chk("beat_data", o_out_data, ed);
                chk("beat_mask", o_out_lane_mask, em);
                chk("beat_last", o_out_last, (m_left <= 8));
                if ((scen == 1 || scen == 8) && start_scen == scen) begin
                    lit = '0;
                    for (int i = 0; i < 8; i++) lit[i*32 +: 32] = 32'(i + 1);
                    chk("s1_data", o_out_data, lit);
                    chk("s1_mask", o_out_lane_mask, 8'hFF);
                    chk("s1_last", o_out_last, 1);
                end
                if (scen == 3 && start_scen == 3) begin
                    lit = '0;
                    lit[31:0] = 32'h00ABCDEF;
                    chk("s3_data", o_out_data, lit);
                    chk("s3_mask", o_out_lane_mask, 8'h01);
                end
                if (scen == 2 && start_scen == 2 && i_out_ready && m_beats < 3) begin
                    chk("s2_mask", o_out_lane_mask, mask_tbl[m_beats]);
                    chk("s2_last", o_out_last, (m_beats == 2));
                end
            end
            if ((scen == 1 || scen == 8) && start_scen == scen) begin
                if (cyc == 9)  chk("s1_valid_c9", o_out_valid, 0);
                if (cyc == 10) chk("s1_valid_c10", o_out_valid, 1);
                if (cyc == 11) begin
                    chk("s1_done_c11", o_done, 1);
                    chk("s1_beats", o_beats_sent, 1);
                end
            end
            if (o_done) begin
                chk("pops", pops - pops0, m_count);
                if (scen == 4) chk("s4_done_c1", cyc, 1);
                if (scen == 2) chk("s2_beats", o_beats_sent, 3);
                if (scen == 5) chk("s5_beats", o_beats_sent, 2);
                if (scen == 6) chk("s6_pops", pops - pops0, 8);
            end
        end
        // Advance the model to the next cycle.
        nd = 0;
        if (i_reset) begin
            m_busy = 0;
            m_left = 0;
            m_beats = 0;
            ref_idx = ref_words.size();
            prev_stall = 0;
            armed = 1;
            rst_prev = 1;
        end else if (armed) begin
            rst_prev = 0;
            if (!m_busy && !m_done && i_start) begin
                m_count = int'(i_drain_count);
                m_beats = 0;
                pops0 = pops;
                cyc = 0;
                start_scen = scen;
                if (i_drain_count == '0) nd = 1;
                else begin
                    m_busy = 1;
                    m_left = int'(i_drain_count);
                end
            end else if (m_busy && o_out_valid && i_out_ready) begin
                n = (m_left < 8) ? m_left : 8;
                ref_idx = ref_idx + n;
                m_left = m_left - n;
                m_beats = m_beats + 1;
                if (m_left == 0) begin
                    m_busy = 0;
                    nd = 1;
                end
            end
            prev_stall = o_out_valid && !i_out_ready;
            prev_data = o_out_data;
            prev_mask = o_out_lane_mask;
            prev_last = o_out_last;
        end
        m_done = nd;
    end

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_seq(input int n, input logic [23:0] base);
        for (int i = 0; i < n; i++) begin
            push_valid = 1'b1;
            push_data = base + 24'(i);
            step();
        end
        push_valid = 1'b0;
    endtask

    task automatic run_drain(input int cnt, input int npush, input int push_pct,
                             input int rdy_pct, input int hold, input bit spam);
        int pushed = 0;
        int k = 0;
        bit spam_send = 0;
        i_drain_count = CNT_W'(cnt);
        i_out_ready = ($urandom_range(99) < rdy_pct);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        while (!o_done && k < 3000) begin
            i_start = 1'b0;
            push_valid = (pushed < npush) && (k >= hold) && ($urandom_range(99) < push_pct);
            if (push_valid) begin
                push_data = 24'($urandom);
                pushed++;
            end
            i_out_ready = ($urandom_range(99) < rdy_pct);
            if (spam && (k == 2 || (o_out_valid && !spam_send))) begin
                i_start = 1'b1;
                i_drain_count = CNT_W'($urandom_range(1, 50));
                if (k != 2) spam_send = 1;
            end
            step();
            k++;
        end
        push_valid = 1'b0;
        i_start = 1'b0;
        if (!o_done) timed_out = 1'b1;
        step();
    endtask

    initial begin
        int k;
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        step(); step();

        scen = 1;
        push_seq(8, 24'h000001);
        step(); step();
        run_drain(8, 0, 100, 100, 0, 0);

        scen = 2;
        run_drain(20, 20, 100, 50, 0, 0);

        scen = 3;
        push_seq(1, 24'hABCDEF);
        step();
        run_drain(1, 0, 100, 100, 0, 0);
        scen = 4;
        run_drain(0, 0, 100, 100, 0, 0);

        scen = 5;
        run_drain(16, 16, 100, 100, 30, 0);

        scen = 6;
        push_seq(8, 24'h000100);
        step();
        run_drain(8, 0, 100, 100, 0, 1);

        scen = 7;
        push_seq(16, 24'h000200);
        step();
        i_drain_count = CNT_W'(16);
        i_out_ready = 1'b0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        k = 0;
        while (!o_out_valid && k < 200) begin
            step();
            k++;
        end
        if (!o_out_valid) timed_out = 1'b1;
        step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();

        scen = 8;
        push_seq(8, 24'h000001);
        step(); step();
        run_drain(8, 0, 100, 100, 0, 0);

        scen = 9;
        for (int d = 0; d < 8; d++) begin
            int c;
            c = $urandom_range(1, 40);
            run_drain(c, c, $urandom_range(30, 100), $urandom_range(30, 100),
                      $urandom_range(0, 5), 0);
        end

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
